// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a valid/ready instruction
// memory and loads the IF/ID pipeline register, with branch/jump redirect and stall.
module if_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc_out,
    input  logic [ADDR_W-1:0] pc_plus4_in,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              freeze,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] ifid_pc4,
    output logic [INST_W-1:0] ifid_inst,
    output logic              ifid_valid
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_KILL  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] buf_pc4;
    logic [INST_W-1:0] buf_inst;
    logic [ADDR_W-1:0] kill_addr;
    logic              redirect;
    logic [ADDR_W-1:0] target;

    always_comb begin
        redirect    = branch_taken | jump;
        target      = branch_taken ? branch_target : jump_target;
        target[1:0] = '0;
    end

    // KILL keeps presenting the abandoned address until memory completes it
    assign pc_out    = pc;
    assign imem_req  = (state == S_FETCH) || (state == S_KILL);
    assign imem_addr = (state == S_KILL) ? kill_addr : pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            ifid_pc4   <= '0;
            ifid_inst  <= '0;
            ifid_valid <= 1'b0;
            buf_pc4    <= '0;
            buf_inst   <= '0;
            kill_addr  <= '0;
        end else begin
            case (state)
                S_BOOT: state <= S_FETCH;
                S_FETCH: begin
                    if (redirect) begin
                        pc         <= target;
                        ifid_valid <= 1'b0;
                        if (!imem_ready) begin
                            kill_addr <= pc;
                            state     <= S_KILL;
                        end
                    end else if (imem_ready) begin
                        if (freeze) begin
                            buf_pc4  <= pc_plus4_in;
                            buf_inst <= imem_rdata;
                            state    <= S_HOLD;
                        end else begin
                            ifid_pc4   <= pc_plus4_in;
                            ifid_inst  <= imem_rdata;
                            ifid_valid <= 1'b1;
                            pc         <= pc_plus4_in;
                        end
                    end else if (!freeze) begin
                        ifid_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc         <= target;
                        ifid_valid <= 1'b0;
                        state      <= S_FETCH;
                    end else if (!freeze) begin
                        ifid_pc4   <= buf_pc4;
                        ifid_inst  <= buf_inst;
                        ifid_valid <= 1'b1;
                        pc         <= buf_pc4;
                        state      <= S_FETCH;
                    end
                end
                default: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    if (imem_ready) begin
                        state <= S_FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed pipeline scenarios followed by random
// stimulus, all checked against a transaction-level model of the fetch stage.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_out, pc_plus4_in;
    logic        branch_taken, jump, freeze;
    logic [31:0] branch_target, jump_target;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] ifid_pc4, ifid_inst;
    logic        ifid_valid;
    logic        late_junk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    if_fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .pc_plus4_in(pc_plus4_in),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .freeze(freeze),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .ifid_pc4(ifid_pc4), .ifid_inst(ifid_inst),
        .ifid_valid(ifid_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign pc_plus4_in = pc_out + 32'd4;
    assign imem_rdata  = late_junk ? 32'hDEAD_BEEF : mem_word(imem_addr);

    // Reference model: PC, IF/ID contents, a queue of instructions accepted
    // while stalled, and a queue of abandoned requests still owed a response.
    typedef struct { logic [31:0] pc4; logic [31:0] inst; } fetched_t;
    fetched_t    held_q[$];
    logic [31:0] orphan_q[$];
    logic [31:0] m_pc = '0, m_pc4 = '0, m_inst = '0;
    logic        m_valid = 1'b0, m_boot = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        fetched_t    f;
        redir = branch_taken | jump;
        tgt   = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
        if (rst) begin
            m_pc = 32'h0; m_pc4 = '0; m_inst = '0; m_valid = 1'b0; m_boot = 1'b1;
            held_q.delete(); orphan_q.delete();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (orphan_q.size() != 0) begin
            if (redir) m_pc = tgt;
            if (imem_ready) orphan_q.delete();
        end else if (held_q.size() != 0) begin
            if (redir) begin
                held_q.delete(); m_pc = tgt; m_valid = 1'b0;
            end else if (!freeze) begin
                f = held_q.pop_front();
                m_pc4 = f.pc4; m_inst = f.inst; m_valid = 1'b1; m_pc = f.pc4;
            end
        end else begin
            if (redir) begin
                if (!imem_ready) orphan_q.push_back(m_pc);
                m_pc = tgt; m_valid = 1'b0;
            end else if (imem_ready) begin
                f.pc4 = m_pc + 32'd4; f.inst = mem_word(m_pc);
                if (freeze) held_q.push_back(f);
                else begin
                    m_pc4 = f.pc4; m_inst = f.inst; m_valid = 1'b1; m_pc = f.pc4;
                end
            end else if (!freeze) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare();
        logic exp_req;
        exp_req = !m_boot && (held_q.size() == 0);
        chk("pc_out", pc_out, m_pc);
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req)
            chk("imem_addr", imem_addr, (orphan_q.size() != 0) ? orphan_q[0] : m_pc);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        chk("ifid_pc4", ifid_pc4, m_pc4);
        chk("ifid_inst", ifid_inst, m_inst);
    endtask

    task automatic cyc(input logic r, input logic fz, input logic rdy,
                       input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
        rst = r; freeze = fz; imem_ready = rdy;
        branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int unsigned n, input logic fz, input logic rdy);
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, fz, rdy, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic restart();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_ifid", ifid_inst | ifid_pc4 | {31'b0, ifid_valid}, 32'h0);
        run(1, 1'b0, 1'b1);
    endtask

    initial begin
        late_junk = 1'b0;
        rst = 1'b1; freeze = 1'b0; imem_ready = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; branch_target = '0; jump_target = '0;

        // zero-wait streaming
        restart();
        run(3, 1'b0, 1'b1);
        chk("t1_pc", pc_out, 32'hC);
        chk("t1_pc4", ifid_pc4, 32'hC);

        // wait states at pc=8
        restart();
        run(2, 1'b0, 1'b1);
        run(3, 1'b0, 1'b0);
        chk("t2_addr", imem_addr, 32'h8);
        chk("t2_bubble", {31'b0, ifid_valid}, 32'h0);
        run(1, 1'b0, 1'b1);
        chk("t2_inst", ifid_inst, mem_word(32'h8));
        chk("t2_pc4", ifid_pc4, 32'hC);

        // stall while a response arrives at pc=4
        restart();
        run(1, 1'b0, 1'b1);
        run(2, 1'b1, 1'b1);
        chk("t3_hold_inst", ifid_inst, mem_word(32'h0));
        chk("t3_hold_req", {31'b0, imem_req}, 32'h0);
        run(1, 1'b0, 1'b1);
        chk("t3_inst", ifid_inst, mem_word(32'h4));
        chk("t3_pc", pc_out, 32'h8);

        // branch while waiting: late response must be discarded
        restart();
        run(4, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h43, 1'b0, '0);
        chk("t4_kill_addr", imem_addr, 32'h10);
        late_junk = 1'b1;
        run(1, 1'b0, 1'b1);
        late_junk = 1'b0;
        chk("t4_addr", imem_addr, 32'h40);
        chk("t4_valid", {31'b0, ifid_valid}, 32'h0);
        run(1, 1'b0, 1'b1);
        chk("t4_inst", ifid_inst, mem_word(32'h40));

        // branch beats jump, both beat freeze
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h100);
        chk("t5_pc", pc_out, 32'h80);
        chk("t5_valid", {31'b0, ifid_valid}, 32'h0);

        // reset from KILL
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h200);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("t6_pc", pc_out, 32'h0);
        chk("t6_req", {31'b0, imem_req}, 32'h0);
        run(1, 1'b0, 1'b0);
        chk("t6_fetch_req", {31'b0, imem_req}, 32'h1);

        // PC wrap at the top of the address space
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'hFFFF_FFFF);
        run(1, 1'b0, 1'b1);
        chk("wrap_pc", pc_out, 32'h0);

        // random traffic
        for (int unsigned i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25),
                ($urandom_range(0, 99) < 65),
                ($urandom_range(0, 99) < 8), $urandom(),
                ($urandom_range(0, 99) < 8), $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
